// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the clock-divider scale controller.
// Holds the controller FSM state encoding and the scale clamp function.
package clk_div_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  // Saturate a requested scale into [lo, hi]; done at 32 bits so any
  // host value can be compared before it is narrowed to the scale width.
  function automatic int unsigned clamp_scale(input int unsigned value,
                                              input int unsigned lo,
                                              input int unsigned hi);
    if (value < lo) return lo;
    if (value > hi) return hi;
    return value;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button conditioner: 2-flop synchroniser, debounce counter and
// rising-edge detector producing a 1-cycle press pulse.
// Build option AUTO_REPEAT_EN: a held button also emits a press every
// REPEAT_CYCLES cycles (REPEAT_CYCLES only exists when the option is on).
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
`ifdef AUTO_REPEAT_EN
  , parameter int REPEAT_CYCLES = 1024
`endif
) (
  input  logic clk_in,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          edge_q;
  logic [CW-1:0] cnt_q;

  // Synchronise, then flip the debounced level after DEBOUNCE_CYCLES
  // consecutive samples that disagree with it; any agreeing sample restarts.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      edge_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      edge_q  <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= sync2_q;
        edge_q  <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rpt_cnt_q;
  logic          rpt_q;

  // Repeat timer: restarts on each press edge, clears on release.
  always_ff @(posedge clk_in) begin
    if (rst || !level_q || edge_q) begin
      rpt_cnt_q <= '0;
      rpt_q     <= 1'b0;
    end else if (rpt_cnt_q == RPT_LAST) begin
      rpt_cnt_q <= '0;
      rpt_q     <= 1'b1;
    end else begin
      rpt_cnt_q <= rpt_cnt_q + 1'b1;
      rpt_q     <= 1'b0;
    end
  end

  assign press_o = edge_q | rpt_q;
`else
  assign press_o = edge_q;
`endif

endmodule

// File: rtl/clk_div_scale_ctrl.sv
// Scale controller for clock_divider: buttons and a host load port set a
// saturating scale; every accepted change holds the divider's active-low
// reset for RST_PULSE cycles so the divider resamples the new scale.
// Build option AUTO_REPEAT_EN enables button auto-repeat (adds REPEAT_CYCLES).
module clk_div_scale_ctrl
  import clk_div_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int SCALE_INIT      = 1,
  parameter int SCALE_MIN       = 0,
  parameter int SCALE_MAX       = 255,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RST_PULSE       = 4
`ifdef AUTO_REPEAT_EN
  , parameter int REPEAT_CYCLES = 1024
`endif
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic [WIDTH-1:0] scale,
  output logic             div_nrst,
  output logic             busy,
  output logic             changed
);

  localparam int CNT_W = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RST_PULSE - 1);
  localparam logic [WIDTH-1:0] S_MIN    = WIDTH'(SCALE_MIN);
  localparam logic [WIDTH-1:0] S_MAX    = WIDTH'(SCALE_MAX);
  localparam logic [WIDTH-1:0] S_INIT   = WIDTH'(SCALE_INIT);

  logic [1:0]       btn_raw;
  logic [1:0]       press;
  logic             press_up;
  logic             press_down;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] scale_q, scale_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             div_nrst_q;

  assign btn_raw    = {btn_down, btn_up};
  assign press_up   = press[0];
  assign press_down = press[1];

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef AUTO_REPEAT_EN
      , .REPEAT_CYCLES(REPEAT_CYCLES)
`endif
    ) u_btn (
      .clk_in (clk_in),
      .rst    (rst),
      .btn_i  (btn_raw[gi]),
      .press_o(press[gi])
    );
  end

  // Next-state logic: IDLE accepts load > up > down; LOAD times the pulse.
  always_comb begin
    state_d    = state_q;
    scale_d    = scale_q;
    cnt_d      = cnt_q;
    load_ready = 1'b0;
    busy       = 1'b0;
    changed    = 1'b0;
    case (state_q)
      IDLE: begin
        load_ready = 1'b1;
        cnt_d      = '0;
        if (load_valid) begin
          scale_d = WIDTH'(clamp_scale(32'(load_data), SCALE_MIN, SCALE_MAX));
          state_d = LOAD;
        end else if (press_up && !press_down) begin
          if (scale_q < S_MAX) begin
            scale_d = scale_q + 1'b1;
            state_d = LOAD;
          end
        end else if (press_down && !press_up) begin
          if (scale_q > S_MIN) begin
            scale_d = scale_q - 1'b1;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        busy = 1'b1;
        if (cnt_q == CNT_LAST) begin
          changed = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // State registers; div_nrst is registered from the next state so it drops
  // on the same edge that commits a new scale.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q    <= LOAD;
      scale_q    <= S_INIT;
      cnt_q      <= '0;
      div_nrst_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      scale_q    <= scale_d;
      cnt_q      <= cnt_d;
      div_nrst_q <= (state_d == IDLE);
    end
  end

  assign scale    = scale_q;
  assign div_nrst = div_nrst_q;

endmodule

// File: tb/tb_clk_div_scale_ctrl.sv
// Scoreboard bench for clk_div_scale_ctrl: stimulus pushes the scale each
// accepted event should produce; a monitor pops on every changed pulse.
module tb_clk_div_scale_ctrl;

  localparam int WIDTH     = 8;
  localparam int SINIT     = 1;
  localparam int SMIN      = 0;
  localparam int SMAX      = 250;
  localparam int DEB       = 16;
  localparam int PULSE     = 4;
`ifdef AUTO_REPEAT_EN
  localparam int REPEAT    = 64;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             btn_up = 1'b0;
  logic             btn_down = 1'b0;
  logic             load_valid = 1'b0;
  logic [WIDTH-1:0] load_data = '0;
  logic             load_ready;
  logic [WIDTH-1:0] scale;
  logic             div_nrst;
  logic             busy;
  logic             changed;

  int vectors = 0;
  int miscompares = 0;
  int model_scale = SINIT;
  int exp_q[$];

  clk_div_scale_ctrl #(
    .WIDTH(WIDTH), .SCALE_INIT(SINIT), .SCALE_MIN(SMIN), .SCALE_MAX(SMAX),
    .DEBOUNCE_CYCLES(DEB), .RST_PULSE(PULSE)
`ifdef AUTO_REPEAT_EN
    , .REPEAT_CYCLES(REPEAT)
`endif
  ) dut (
    .clk_in(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .scale(scale), .div_nrst(div_nrst), .busy(busy), .changed(changed)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int exp_clamp(input int v);
    if (v < SMIN) return SMIN;
    if (v > SMAX) return SMAX;
    return v;
  endfunction

  // Reference rule for one press reaching an idle controller.
  task automatic model_press(input bit up, input bit dn);
    if (up && dn) return;
    if (up) begin
      if (model_scale < SMAX) begin
        model_scale++;
        exp_q.push_back(model_scale);
      end
    end else if (dn) begin
      if (model_scale > SMIN) begin
        model_scale--;
        exp_q.push_back(model_scale);
      end
    end
  endtask

  task automatic press(input bit up, input bit dn, input int hold,
                       input int glitch_len, input int n_glitch);
    for (int g = 0; g < n_glitch; g++) begin
      btn_up = up; btn_down = dn;
      step(glitch_len);
      btn_up = 1'b0; btn_down = 1'b0;
      step(8);
    end
    model_press(up, dn);
`ifdef AUTO_REPEAT_EN
    for (int r = 0; r < (hold - 1) / REPEAT; r++) model_press(up, dn);
`endif
    btn_up = up; btn_down = dn;
    step(hold);
    btn_up = 1'b0; btn_down = 1'b0;
    step(40);
    check("scale_after_press", int'(scale), model_scale);
    check("div_nrst_idle", int'(div_nrst), 1);
  endtask

  task automatic do_load(input int d, input bit keep);
    bit ok;
    ok = 1'b0;
    load_valid = 1'b1;
    load_data  = WIDTH'(d);
    for (int i = 0; i < 50 && !ok; i++) begin
      if (load_ready) begin
        ok = 1'b1;
        model_scale = exp_clamp(d);
        exp_q.push_back(model_scale);
      end
      step(1);
    end
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL load_handshake: no load_ready within 50 cycles (data %0d)", d);
    end
    if (!keep) load_valid = 1'b0;
  endtask

  // Monitor: score every changed pulse and every div_nrst low window.
  int low_cnt = 0;
  bit prev_nrst = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      low_cnt   = 0;
      prev_nrst = div_nrst;
    end else begin
      if (changed) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_changed: scale %0d with nothing expected", scale);
        end else begin
          check("scale_on_changed", int'(scale), exp_q.pop_front());
          check("div_nrst_on_changed", int'(div_nrst), 0);
          check("busy_on_changed", int'(busy), 1);
        end
      end
      if (!div_nrst) begin
        low_cnt++;
      end else begin
        if (!prev_nrst) check("div_nrst_low_len", low_cnt, PULSE);
        low_cnt = 0;
      end
      prev_nrst = div_nrst;
    end
  end

  initial begin
    #500us;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held 3 cycles; outputs reflect the reset load state.
    rst = 1'b1;
    step(3);
    check("rst_scale", int'(scale), SINIT);
    check("rst_div_nrst", int'(div_nrst), 0);
    check("rst_busy", int'(busy), 1);
    check("rst_changed", int'(changed), 0);
    check("rst_load_ready", int'(load_ready), 0);
    model_scale = SINIT;
    exp_q.push_back(SINIT);
    rst = 1'b0;
    step(10);
    check("post_rst_div_nrst", int'(div_nrst), 1);

    // Glitchy button then a clean hold: one increment.
    press(1'b1, 1'b0, 40, 5, 3);

    // Host loads, including an out-of-range value.
    do_load(8'hC8, 1'b0);
    check("load_C8", int'(scale), 200);
    step(10);
    do_load(8'hFF, 1'b0);
    check("load_FF_clamped", int'(scale), SMAX);
    step(10);

    // Saturation at both ends.
    press(1'b1, 1'b0, 30, 15, 1);
    do_load(0, 1'b0);
    step(10);
    press(1'b0, 1'b1, 30, 5, 0);

    // load_valid held through an active LOAD.
    do_load(50, 1'b1);
    load_data = WIDTH'(77);
    check("ready_low_in_load", int'(load_ready), 0);
    check("busy_in_load", int'(busy), 1);
    do_load(77, 1'b0);
    step(10);
    check("second_load", int'(scale), 77);

    // Both buttons together: ignored.
    press(1'b1, 1'b1, 30, 5, 1);

    // Long hold: +1, plus repeats when auto-repeat is built in.
    do_load(10, 1'b0);
    step(10);
    press(1'b1, 1'b0, 300, 5, 0);

    // Randomised mix of loads and presses.
    for (int n = 0; n < 30; n++) begin
      int op;
      op = int'($urandom_range(0, 3));
      case (op)
        0: begin
          do_load(int'($urandom_range(0, 255)), 1'b0);
          step(10);
        end
        1: press(1'b1, 1'b0, int'($urandom_range(20, 60)),
                 ($urandom_range(0, 1) != 0) ? 15 : 5, int'($urandom_range(0, 2)));
        2: press(1'b0, 1'b1, int'($urandom_range(20, 60)),
                 ($urandom_range(0, 1) != 0) ? 15 : 5, int'($urandom_range(0, 2)));
        default: press(1'b1, 1'b1, int'($urandom_range(20, 60)), 5,
                       int'($urandom_range(0, 2)));
      endcase
    end

    step(20);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
